// File: rtl/ex_mem_if.sv
// EX/MEM pipeline register bus: EX-side valid/ready payload in, MEM-side payload out.
// slave is the pipeline register's view; master is the view of whoever drives EX and MEM.
interface ex_mem_if #(
  parameter int unsigned B  = 32,
  parameter int unsigned W  = 5,
  parameter int unsigned CW = 16
);
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [B-1:0] add_result_in;
  logic [B-1:0] alu_result_in;
  logic [B-1:0] r_data2_in;
  logic [W-1:0] reg_dst_in;
  logic         zero_in;
  logic         wb_RegWrite_in;
  logic         wb_MemtoReg_in;
  logic         m_Branch_in;
  logic         m_MemRead_in;
  logic         m_MemWrite_in;

  logic          out_valid;
  logic          out_ready;
  logic [B-1:0]  add_result_out;
  logic [B-1:0]  alu_result_out;
  logic [B-1:0]  r_data2_out;
  logic [W-1:0]  reg_dst_out;
  logic          zero_out;
  logic          wb_RegWrite_out;
  logic          wb_MemtoReg_out;
  logic          m_Branch_out;
  logic          m_MemRead_out;
  logic          m_MemWrite_out;
  logic          m_PCSrc;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cycles;

  modport slave (
    input  flush, in_valid, add_result_in, alu_result_in, r_data2_in, reg_dst_in, zero_in,
           wb_RegWrite_in, wb_MemtoReg_in, m_Branch_in, m_MemRead_in, m_MemWrite_in, out_ready,
    output in_ready, out_valid, add_result_out, alu_result_out, r_data2_out, reg_dst_out,
           zero_out, wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_MemRead_out,
           m_MemWrite_out, m_PCSrc, occupancy, stall_cycles
  );

  modport master (
    output flush, in_valid, add_result_in, alu_result_in, r_data2_in, reg_dst_in, zero_in,
           wb_RegWrite_in, wb_MemtoReg_in, m_Branch_in, m_MemRead_in, m_MemWrite_in, out_ready,
    input  in_ready, out_valid, add_result_out, alu_result_out, r_data2_out, reg_dst_out,
           zero_out, wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_MemRead_out,
           m_MemWrite_out, m_PCSrc, occupancy, stall_cycles
  );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with a 2-entry skid buffer, flush, bubble-safe controls
// and a saturating stall counter.
module ex_mem_pipe_reg #(
  parameter int unsigned B  = 32,
  parameter int unsigned W  = 5,
  parameter int unsigned CW = 16
) (
  input logic         clk,
  input logic         rst,
  ex_mem_if.slave     bus
);

  typedef struct packed {
    logic [B-1:0] add_result;
    logic [B-1:0] alu_result;
    logic [B-1:0] r_data2;
    logic [W-1:0] reg_dst;
    logic         zero;
    logic         wb_reg_write;
    logic         wb_memto_reg;
    logic         m_branch;
    logic         m_mem_read;
    logic         m_mem_write;
  } entry_t;

  // Encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state;
  entry_t        main_q;
  entry_t        skid_q;
  entry_t        in_entry;
  logic [CW-1:0] stall_q;
  logic          in_fire;
  logic          out_fire;

  assign in_entry = '{
    add_result:   bus.add_result_in,
    alu_result:   bus.alu_result_in,
    r_data2:      bus.r_data2_in,
    reg_dst:      bus.reg_dst_in,
    zero:         bus.zero_in,
    wb_reg_write: bus.wb_RegWrite_in,
    wb_memto_reg: bus.wb_MemtoReg_in,
    m_branch:     bus.m_Branch_in,
    m_mem_read:   bus.m_MemRead_in,
    m_mem_write:  bus.m_MemWrite_in
  };

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      if (bus.out_valid && !bus.out_ready && (stall_q != {CW{1'b1}}))
        stall_q <= stall_q + CW'(1);

      // Flush drops every held entry and any input offered in the same cycle.
      if (bus.flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              main_q <= in_entry;
              state  <= HOLD;
            end
          end
          HOLD: begin
            if (in_fire && out_fire) begin
              main_q <= in_entry;
            end else if (in_fire) begin
              skid_q <= in_entry;
              state  <= FULL;
            end else if (out_fire) begin
              state  <= EMPTY;
            end
          end
          FULL: begin
            if (out_fire) begin
              main_q <= skid_q;
              state  <= HOLD;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  assign bus.occupancy      = 2'(state);
  assign bus.stall_cycles   = stall_q;
  assign bus.add_result_out = main_q.add_result;
  assign bus.alu_result_out = main_q.alu_result;
  assign bus.r_data2_out    = main_q.r_data2;
  assign bus.reg_dst_out    = main_q.reg_dst;
  assign bus.zero_out       = main_q.zero;
  assign bus.wb_MemtoReg_out = main_q.wb_memto_reg;

  // Side-effecting controls are masked so a bubble can never write or branch.
  assign bus.wb_RegWrite_out = main_q.wb_reg_write & bus.out_valid;
  assign bus.m_Branch_out    = main_q.m_branch     & bus.out_valid;
  assign bus.m_MemRead_out   = main_q.m_mem_read   & bus.out_valid;
  assign bus.m_MemWrite_out  = main_q.m_mem_write  & bus.out_valid;
  assign bus.m_PCSrc         = main_q.m_branch & main_q.zero & bus.out_valid;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: a queue scoreboard tracks every accepted entry
// and is compared against the MEM-side outputs on each output handshake.
module tb_ex_mem_pipe_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_mem_if #(.B(32), .W(5), .CW(16)) bus ();
  ex_mem_if #(.B(32), .W(5), .CW(3))  sat_bus ();

  ex_mem_pipe_reg #(.B(32), .W(5), .CW(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  ex_mem_pipe_reg #(.B(32), .W(5), .CW(3))  dut_sat (.clk(clk), .rst(rst), .bus(sat_bus));

  typedef struct packed {
    logic [31:0] add;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  rd;
    logic        zero, rw, m2r, br, mr, mw;
  } ent_t;

  ent_t        q[$];
  logic [15:0] exp_stall;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t in_ent();
    return '{bus.add_result_in, bus.alu_result_in, bus.r_data2_in, bus.reg_dst_in,
             bus.zero_in, bus.wb_RegWrite_in, bus.wb_MemtoReg_in, bus.m_Branch_in,
             bus.m_MemRead_in, bus.m_MemWrite_in};
  endfunction

  function automatic ent_t out_ent();
    return '{bus.add_result_out, bus.alu_result_out, bus.r_data2_out, bus.reg_dst_out,
             bus.zero_out, bus.wb_RegWrite_out, bus.wb_MemtoReg_out, bus.m_Branch_out,
             bus.m_MemRead_out, bus.m_MemWrite_out};
  endfunction

  // ctl = {zero, RegWrite, MemtoReg, Branch, MemRead, MemWrite}
  task automatic set_in(input logic v, input logic [31:0] add, input logic [31:0] alu,
                        input logic [31:0] rd2, input logic [4:0] rd, input logic [5:0] ctl);
    bus.in_valid       = v;
    bus.add_result_in  = add;
    bus.alu_result_in  = alu;
    bus.r_data2_in     = rd2;
    bus.reg_dst_in     = rd;
    {bus.zero_in, bus.wb_RegWrite_in, bus.wb_MemtoReg_in,
     bus.m_Branch_in, bus.m_MemRead_in, bus.m_MemWrite_in} = ctl;
  endtask

  // Check handshake state against the model, retire/accept entries, advance one clock.
  task automatic cycle();
    int   sz;
    logic inf, outf;
    ent_t e;
    sz   = q.size();
    inf  = bus.in_valid && (sz < 2);
    outf = (sz > 0) && bus.out_ready;
    chk("in_ready", 128'(bus.in_ready), 128'(sz < 2));
    chk("out_valid", 128'(bus.out_valid), 128'(sz > 0));
    chk("occupancy", 128'(bus.occupancy), 128'(sz));
    if (sz == 0)
      chk("bubble_ctl", 128'({bus.wb_RegWrite_out, bus.m_MemRead_out, bus.m_MemWrite_out,
                              bus.m_Branch_out, bus.m_PCSrc}), 128'(0));
    if ((sz > 0) && !bus.out_ready && (exp_stall != 16'hffff)) exp_stall++;
    if (outf) begin
      e = q.pop_front();
      chk("out_entry", 128'(out_ent()), 128'(e));
      chk("pcsrc", 128'(bus.m_PCSrc), 128'(e.br & e.zero));
    end
    if (bus.flush) q.delete();
    else if (inf) q.push_back(in_ent());
    @(posedge clk);
    #1;
    chk("stall_cycles", 128'(bus.stall_cycles), 128'(exp_stall));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_stall = '0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 6'b0);
    sat_bus.flush = 1'b0;
    sat_bus.out_ready = 1'b0;
    sat_bus.in_valid = 1'b0;
    sat_bus.add_result_in = '0;
    sat_bus.alu_result_in = '0;
    sat_bus.r_data2_in = '0;
    sat_bus.reg_dst_in = '0;
    {sat_bus.zero_in, sat_bus.wb_RegWrite_in, sat_bus.wb_MemtoReg_in,
     sat_bus.m_Branch_in, sat_bus.m_MemRead_in, sat_bus.m_MemWrite_in} = 6'b0;
    #12;
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_occupancy", 128'(bus.occupancy), 128'(0));
    chk("rst_data", 128'(out_ent()), 128'(0));
    chk("rst_stall", 128'(bus.stall_cycles), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // Pass-through with one-cycle latency, then a bubble with RegWrite masked.
    bus.out_ready = 1'b1;
    set_in(1'b1, 32'h0, 32'h10, 32'h0, 5'd5, 6'b010000);
    cycle();
    chk("pt_alu", 128'(bus.alu_result_out), 128'(32'h10));
    chk("pt_rd", 128'(bus.reg_dst_out), 128'(5));
    chk("pt_regwrite", 128'(bus.wb_RegWrite_out), 128'(1));
    bus.in_valid = 1'b0;
    cycle();
    cycle();

    // Back-pressure: A, B fill both entries, C is held off until space frees.
    bus.out_ready = 1'b0;
    set_in(1'b1, 32'h0, 32'h1, 32'hA, 5'd1, 6'b000010);
    cycle();
    set_in(1'b1, 32'h0, 32'h2, 32'hB, 5'd2, 6'b000001);
    cycle();
    set_in(1'b1, 32'h0, 32'h3, 32'hC, 5'd3, 6'b011000);
    for (int i = 0; i < 3; i++) cycle();
    chk("bp_stall_held", 128'(bus.stall_cycles), 128'(4));
    bus.out_ready = 1'b1;
    cycle();
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    cycle();

    // Flush while FULL beats a simultaneous valid input.
    bus.out_ready = 1'b0;
    set_in(1'b1, 32'h0, 32'h21, 32'h0, 5'd7, 6'b000001);
    cycle();
    set_in(1'b1, 32'h0, 32'h22, 32'h0, 5'd8, 6'b000001);
    cycle();
    set_in(1'b1, 32'h0, 32'h99, 32'h0, 5'd9, 6'b000001);
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_stale_alu", 128'(bus.alu_result_out), 128'(32'h21));
    chk("fl_memwrite", 128'(bus.m_MemWrite_out), 128'(0));
    bus.out_ready = 1'b1;
    cycle();
    cycle();

    // Branch taken then not taken.
    set_in(1'b1, 32'h40, 32'h0, 32'h0, 5'd0, 6'b100100);
    cycle();
    chk("br_pcsrc_taken", 128'(bus.m_PCSrc), 128'(1));
    chk("br_target", 128'(bus.add_result_out), 128'(32'h40));
    set_in(1'b1, 32'h44, 32'h0, 32'h0, 5'd0, 6'b000100);
    cycle();
    chk("br_pcsrc_nottaken", 128'(bus.m_PCSrc), 128'(0));
    bus.in_valid = 1'b0;
    cycle();
    cycle();

    // Asynchronous reset between edges while FULL.
    bus.out_ready = 1'b0;
    set_in(1'b1, 32'h5, 32'h61, 32'h7, 5'd11, 6'b011111);
    cycle();
    set_in(1'b1, 32'h6, 32'h62, 32'h8, 5'd12, 6'b011111);
    cycle();
    bus.in_valid = 1'b0;
    chk("ar_pre_full", 128'(bus.occupancy), 128'(2));
    #2;
    rst = 1'b1;
    #1;
    chk("ar_in_ready", 128'(bus.in_ready), 128'(1));
    chk("ar_out_valid", 128'(bus.out_valid), 128'(0));
    chk("ar_occupancy", 128'(bus.occupancy), 128'(0));
    chk("ar_data", 128'(out_ent()), 128'(0));
    chk("ar_stall", 128'(bus.stall_cycles), 128'(0));
    q.delete();
    exp_stall = '0;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    set_in(1'b1, 32'h0, 32'h55, 32'h0, 5'd13, 6'b010000);
    cycle();
    chk("ar_resume_alu", 128'(bus.alu_result_out), 128'(32'h55));
    bus.in_valid = 1'b0;
    cycle();
    cycle();

    // Stall counter saturation on a 3-bit instance.
    sat_bus.in_valid = 1'b1;
    sat_bus.alu_result_in = 32'h77;
    @(posedge clk);
    #1;
    sat_bus.in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      chk("sat_stall", 128'(sat_bus.stall_cycles), 128'((i > 7) ? 7 : i));
    end
    chk("sat_out_valid", 128'(sat_bus.out_valid), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
